back1_rom_fetch_cache: RTL and testbench
========================================

Name: back1_rom_fetch_cache

Overview:
- Sits between the Back1 tile layer's ROM port (rom_addr/rom_req/rom_ack/rom_data, toggle handshake) and one SDRAM controller channel, which uses the same toggle handshake.
- Holds a small direct-mapped cache of 16-bit ROM words, so repeated tile-row fetches during a scanline hit without an SDRAM access.
- Fixes stale-data delivery: if the core address changes during a fetch, the fetch result is not acknowledged and the lookup restarts.

Parameters:
- IDX_W, 4, cache index width; the cache holds 2^IDX_W entries.
- ADDR_W, 24, word address width on both sides.
- ROM_BASE, 24'h020000, word offset of the Back1 ROM region in SDRAM; added to the core address.

Ports:
- clk  in  1  system clock; single clock domain.
- VIDEO_RSTn  in  1  asynchronous active-low reset.
- flush  in  1  level; high while ROMs download; invalidates the cache.
- core_addr  in  ADDR_W  word address from Back1.
- core_req  in  1  request toggle from Back1.
- core_ack  out  1  acknowledge toggle to Back1.
- core_data  out  16  returned ROM word.
- sdr_addr  out  ADDR_W  SDRAM word address.
- sdr_req  out  1  request toggle to SDRAM.
- sdr_ack  in  1  acknowledge toggle from SDRAM.
- sdr_data  in  16  SDRAM read data; valid when sdr_ack==sdr_req.
- hit_cnt  out  16  saturating hit counter (debug).

Behaviour:
- Reset values: core_ack=0, core_data=0, sdr_req=0, sdr_addr=0, hit_cnt=0, all valid bits=0, state=RESYNC.
- Pending request: core_req != core_ack. Address split: idx = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W].
- Storage: tag RAM, data RAM and a per-entry valid vector. The tag and data RAMs have a registered read.
- States:
  - RESYNC: wait until sdr_ack==sdr_req (absorbs a controller ack still in flight across reset), then go to IDLE.
  - IDLE: if flush=0 and a request is pending, capture cap_addr=core_addr and cap_req=core_req, issue the RAM read at idx, then go to LOOKUP.
  - LOOKUP: compare tag and valid.
    - On a hit: core_data<=data, core_ack<=cap_req, hit_cnt+1 (saturates at 16'hFFFF), go to IDLE. Hit latency is 2 clk from the cycle the pending request is seen in IDLE.
    - On a miss: sdr_addr<=cap_addr+ROM_BASE (modulo 2^ADDR_W), sdr_req<=~sdr_req, go to FETCH.
  - FETCH: wait for sdr_ack==sdr_req. Then write data and tag, set valid[idx], and compare core_addr with cap_addr.
    - Equal: core_data<=sdr_data, core_ack<=cap_req, go to IDLE.
    - Different (address changed mid-fetch): keep the cache fill, do not touch core_ack, go to IDLE. Because the request is still pending, IDLE recaptures the new address.
- core_data is stable whenever core_req==core_ack, since Back1 samples it continuously.
- core_req re-toggles during LOOKUP/FETCH: no effect other than through the address-compare rule; cap_req is not updated.
- flush=1:
  - Every valid bit clears on each flush cycle, and hit_cnt clears.
  - IDLE does not accept requests while flush=1.
  - An outstanding FETCH completes, but its fill write is suppressed if flush was high at any time during the fetch.
  - Requests are served normally after flush falls.
- Reset asserted mid-FETCH: all state returns to reset values immediately. RESYNC then prevents a late sdr_ack from being taken as a new completion.
- Only one SDRAM request is outstanding at a time. sdr_addr is held stable from the toggle until the ack.

Test Plan:
- Cold miss:
  - Stimulus: after reset, core_addr=24'h000123, core_req toggles to 1.
  - Required: sdr_addr=24'h020123 and sdr_req=1. When the model returns 16'hBEEF with sdr_ack=1, core_data=16'hBEEF and core_ack=1.
- Hit:
  - Stimulus: re-request 24'h000123 (toggle core_req to 0).
  - Required: no sdr_req change; core_data=16'hBEEF and core_ack=0 exactly 2 clk later; hit_cnt=1.
- Conflict:
  - Stimulus: request 24'h000133 (same idx 3, different tag), then 24'h000123.
  - Required: both miss with two SDRAM toggles; core_data tracks each return.
- Mid-fetch address change:
  - Stimulus: request 24'h000010; change core_addr to 24'h000011 before the SDRAM ack.
  - Required: core_ack is unchanged at the first completion. A second SDRAM fetch goes to 24'h020011, then core_data equals its data and core_ack toggles.
- Flush:
  - Stimulus: fill 24'h000123; pulse flush for 3 clk; re-request 24'h000123.
  - Required: a miss (SDRAM toggle) and hit_cnt=0. A request raised during flush is served only after flush falls.
- Reset mid-fetch:
  - Stimulus: assert VIDEO_RSTn=0 while in FETCH; the SDRAM model acks 2 clk after release.
  - Required: all outputs are 0 during reset. The block stays in RESYNC until sdr_ack==sdr_req, and core_ack does not toggle spuriously.

Source files
------------

// File: rtl/back1_rom_fetch_cache.sv
`timescale 1ns/1ps
// Direct-mapped cache of 16-bit ROM words between Back1's toggle port and one SDRAM channel.
// Hit: core_ack 2 clk after the request is seen in IDLE; miss waits on sdr_ack; one SDRAM request in flight.
module back1_rom_fetch_cache #(
  parameter int                IDX_W    = 4,
  parameter int                ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] ROM_BASE = 24'h020000
) (
  input  logic              clk,
  input  logic              VIDEO_RSTn,
  input  logic              flush,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_req,
  output logic              core_ack,
  output logic [15:0]       core_data,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic              sdr_req,
  input  logic              sdr_ack,
  input  logic [15:0]       sdr_data,
  output logic [15:0]       hit_cnt
);

  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {RESYNC, IDLE, LOOKUP, FETCH} state_t;

  state_t            state;
  logic [TAG_W-1:0]  tag_ram  [DEPTH];
  logic [15:0]       data_ram [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_req;
  logic [TAG_W-1:0]  rd_tag;
  logic [15:0]       rd_data;
  logic              flush_seen;

  logic [IDX_W-1:0]  cap_idx;
  logic [TAG_W-1:0]  cap_tag;
  logic              sdr_done;
  logic              pending;
  logic              hit;
  logic              fill_we;

  assign cap_idx  = cap_addr[IDX_W-1:0];
  assign cap_tag  = cap_addr[ADDR_W-1:IDX_W];
  assign sdr_done = (sdr_ack == sdr_req);
  assign pending  = (core_req != core_ack);
  assign hit      = valid[cap_idx] && (rd_tag == cap_tag) && !flush;
  // A fill is dropped if flush was seen at any point while the fetch was outstanding.
  assign fill_we  = (state == FETCH) && sdr_done && !flush_seen && !flush;

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_ram[cap_idx]  <= cap_tag;
      data_ram[cap_idx] <= sdr_data;
    end
    if (state == IDLE) begin
      rd_tag  <= tag_ram[core_addr[IDX_W-1:0]];
      rd_data <= data_ram[core_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      state      <= RESYNC;
      core_ack   <= 1'b0;
      core_data  <= 16'h0000;
      sdr_req    <= 1'b0;
      sdr_addr   <= '0;
      hit_cnt    <= 16'h0000;
      valid      <= '0;
      cap_addr   <= '0;
      cap_req    <= 1'b0;
      flush_seen <= 1'b0;
    end else begin
      case (state)
        RESYNC: begin
          if (sdr_done) state <= IDLE;
        end
        IDLE: begin
          // A stray controller ack (left over from before reset) sends us back to realign.
          if (!sdr_done) begin
            state <= RESYNC;
          end else if (!flush && pending) begin
            cap_addr <= core_addr;
            cap_req  <= core_req;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            core_data <= rd_data;
            core_ack  <= cap_req;
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            state <= IDLE;
          end else if (!sdr_done) begin
            state <= RESYNC;
          end else begin
            sdr_addr   <= cap_addr + ROM_BASE;
            sdr_req    <= ~sdr_req;
            flush_seen <= flush;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (flush) flush_seen <= 1'b1;
          if (sdr_done) begin
            if (fill_we) valid[cap_idx] <= 1'b1;
            // Only acknowledge when the core is still asking for the fetched word.
            if (core_addr == cap_addr) begin
              core_data <= sdr_data;
              core_ack  <= cap_req;
            end
            state <= IDLE;
          end
        end
        default: state <= RESYNC;
      endcase
      if (flush) begin
        valid   <= '0;
        hit_cnt <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_back1_rom_fetch_cache.sv
`timescale 1ns/1ps
// Scoreboard bench: expected fetch addresses and returned words are queued at stimulus time.
module tb_back1_rom_fetch_cache;

  localparam logic [23:0] BASE = 24'h020000;

  logic        clk = 1'b0;
  logic        VIDEO_RSTn;
  logic        flush;
  logic [23:0] core_addr;
  logic        core_req;
  logic        core_ack;
  logic [15:0] core_data;
  logic [23:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_ack;
  logic [15:0] sdr_data;
  logic [15:0] hit_cnt;

  int tests = 0;
  int fails = 0;

  logic [23:0] sdr_q[$];
  logic [15:0] exp_q[$];
  int   n_fetch  = 0;
  int   mdl_lat  = 3;
  bit   mdl_en   = 1'b1;
  int   man_seq  = 0;
  logic man_val  = 1'b0;

  back1_rom_fetch_cache #(.IDX_W(4), .ADDR_W(24), .ROM_BASE(BASE)) dut (
    .clk(clk), .VIDEO_RSTn(VIDEO_RSTn), .flush(flush),
    .core_addr(core_addr), .core_req(core_req), .core_ack(core_ack), .core_data(core_data),
    .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_data(sdr_data),
    .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fdata(input logic [23:0] a);
    if (a == 24'h020123) return 16'hBEEF;
    return a[15:0] ^ 16'h5A00;
  endfunction

  // SDRAM channel model: follows the request toggle after mdl_lat clocks.
  initial begin
    int          seen;
    logic        tgt;
    logic [23:0] a;
    logic [23:0] e;
    bit          stable;
    seen = 0;
    sdr_ack = 1'b0;
    sdr_data = 16'h0000;
    forever begin
      @(posedge clk); #2;
      if (man_seq != seen) begin
        seen = man_seq;
        sdr_ack = man_val;
        sdr_data = 16'hDEAD;
      end else if (mdl_en && VIDEO_RSTn && sdr_req !== sdr_ack) begin
        tgt = sdr_req;
        a = sdr_addr;
        n_fetch++;
        tests++;
        if (sdr_q.size() == 0) begin
          fails++;
          $display("FAIL sdr_unexpected_fetch: addr=%h, no fetch expected", a);
        end else begin
          e = sdr_q.pop_front();
          if (a !== e) begin
            fails++;
            $display("FAIL sdr_addr: got %h expected %h", a, e);
          end
        end
        stable = 1'b1;
        repeat (mdl_lat) begin
          @(posedge clk); #2;
          if (sdr_addr !== a || sdr_req !== tgt) stable = 1'b0;
        end
        tests++;
        if (!stable) begin
          fails++;
          $display("FAIL sdr_addr_stable: addr/req moved during fetch of %h (now %h)", a, sdr_addr);
        end
        sdr_data = fdata(a);
        sdr_ack = tgt;
      end
    end
  end

  // Output monitor: every core_ack toggle must match the next expected word.
  initial begin
    logic        prev;
    logic [15:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!VIDEO_RSTn) begin
        prev = 1'b0;
      end else if (core_ack !== prev) begin
        prev = core_ack;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_core_ack: ack=%b data=%h with nothing expected", core_ack, core_data);
        end else begin
          e = exp_q.pop_front();
          if (core_data !== e) begin
            fails++;
            $display("FAIL core_data_sb: got %h expected %h", core_data, e);
          end
        end
      end
    end
  end

  task automatic do_req(input logic [23:0] addr, input bit miss, output bit ok);
    @(posedge clk); #1;
    exp_q.push_back(fdata(addr + BASE));
    if (miss) sdr_q.push_back(addr + BASE);
    core_addr = addr;
    core_req = ~core_req;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (core_ack === core_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    VIDEO_RSTn = 1'b0; flush = 1'b0; core_addr = '0; core_req = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (core_ack !== 1'b0)   begin fails++; $display("FAIL reset_core_ack: got %b expected 0", core_ack); end
    tests++; if (core_data !== 16'h0) begin fails++; $display("FAIL reset_core_data: got %h expected 0000", core_data); end
    tests++; if (sdr_req !== 1'b0)    begin fails++; $display("FAIL reset_sdr_req: got %b expected 0", sdr_req); end
    tests++; if (sdr_addr !== 24'h0)  begin fails++; $display("FAIL reset_sdr_addr: got %h expected 000000", sdr_addr); end
    tests++; if (hit_cnt !== 16'h0)   begin fails++; $display("FAIL reset_hit_cnt: got %h expected 0000", hit_cnt); end
    VIDEO_RSTn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cold_miss;
    bit ok;
    int nf0 = n_fetch;
    do_req(24'h000123, 1'b1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL cold_timeout: core_ack=%b core_req=%b", core_ack, core_req); end
    tests++; if (core_data !== 16'hBEEF) begin fails++; $display("FAIL cold_data: got %h expected BEEF", core_data); end
    tests++; if (core_ack !== 1'b1) begin fails++; $display("FAIL cold_ack: got %b expected 1", core_ack); end
    tests++; if (sdr_addr !== 24'h020123 || sdr_req !== 1'b1) begin
      fails++; $display("FAIL cold_sdr: addr=%h req=%b expected 020123/1", sdr_addr, sdr_req); end
    tests++; if (n_fetch !== nf0 + 1) begin fails++; $display("FAIL cold_fetch_cnt: got %0d expected %0d", n_fetch - nf0, 1); end
  endtask

  task automatic test_hit;
    logic sr = sdr_req;
    int   nf0 = n_fetch;
    @(posedge clk); #1;
    exp_q.push_back(16'hBEEF);
    core_addr = 24'h000123;
    core_req = ~core_req;
    @(negedge clk);
    tests++; if (core_ack === core_req) begin fails++; $display("FAIL hit_early0: ack=%b already equals req", core_ack); end
    @(posedge clk); @(negedge clk);
    tests++; if (core_ack === core_req) begin fails++; $display("FAIL hit_early1: ack=%b after 1 clk, expected 2", core_ack); end
    @(posedge clk); @(negedge clk);
    tests++; if (core_ack !== 1'b0 || core_data !== 16'hBEEF) begin
      fails++; $display("FAIL hit_2clk: ack=%b data=%h expected 0/BEEF", core_ack, core_data); end
    tests++; if (hit_cnt !== 16'd1) begin fails++; $display("FAIL hit_cnt: got %0d expected 1", hit_cnt); end
    tests++; if (sdr_req !== sr || n_fetch !== nf0) begin
      fails++; $display("FAIL hit_no_sdr: sdr_req=%b fetches=%0d expected %b/0", sdr_req, n_fetch - nf0, sr); end
  endtask

  task automatic test_conflict;
    bit ok;
    int nf0 = n_fetch;
    do_req(24'h000133, 1'b1, ok);
    tests++; if (!ok || core_data !== 16'h5B33) begin
      fails++; $display("FAIL conflict_a: ok=%b data=%h expected 1/5B33", ok, core_data); end
    do_req(24'h000123, 1'b1, ok);
    tests++; if (!ok || core_data !== 16'hBEEF) begin
      fails++; $display("FAIL conflict_b: ok=%b data=%h expected 1/BEEF", ok, core_data); end
    tests++; if (n_fetch !== nf0 + 2) begin fails++; $display("FAIL conflict_fetches: got %0d expected 2", n_fetch - nf0); end
  endtask

  task automatic test_mid_fetch;
    bit ok = 1'b0;
    bit st = 1'b0;
    int nf0 = n_fetch;
    mdl_lat = 8;
    @(posedge clk); #1;
    sdr_q.push_back(24'h020010);
    sdr_q.push_back(24'h020011);
    exp_q.push_back(16'h5A11);
    core_addr = 24'h000010;
    core_req = ~core_req;
    for (int i = 0; i < 50 && !st; i++) begin @(negedge clk); if (sdr_req !== sdr_ack) st = 1'b1; end
    core_addr = 24'h000011;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk); if (core_ack === core_req) ok = 1'b1; end
    tests++; if (!st || !ok) begin fails++; $display("FAIL mid_timeout: started=%b acked=%b", st, ok); end
    tests++; if (n_fetch !== nf0 + 2) begin fails++; $display("FAIL mid_fetches: got %0d expected 2", n_fetch - nf0); end
    tests++; if (core_data !== 16'h5A11) begin fails++; $display("FAIL mid_data: got %h expected 5A11", core_data); end
    mdl_lat = 3;
  endtask

  task automatic test_flush;
    bit ok = 1'b0;
    int nf0 = n_fetch;
    @(posedge clk); #1;
    flush = 1'b1;
    sdr_q.push_back(24'h020123);
    exp_q.push_back(16'hBEEF);
    core_addr = 24'h000123;
    core_req = ~core_req;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (core_ack === core_req || n_fetch !== nf0) begin
      fails++; $display("FAIL flush_blocks: ack=%b req=%b fetches=%0d expected unserved", core_ack, core_req, n_fetch - nf0); end
    tests++; if (hit_cnt !== 16'd0) begin fails++; $display("FAIL flush_hit_cnt: got %0d expected 0", hit_cnt); end
    flush = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); if (core_ack === core_req) ok = 1'b1; end
    tests++; if (!ok || core_data !== 16'hBEEF) begin fails++; $display("FAIL flush_refetch: ok=%b data=%h", ok, core_data); end
    tests++; if (n_fetch !== nf0 + 1 || hit_cnt !== 16'd0) begin
      fails++; $display("FAIL flush_miss: fetches=%0d hit_cnt=%0d expected 1/0", n_fetch - nf0, hit_cnt); end
  endtask

  task automatic test_flush_mid_fetch;
    bit ok = 1'b0;
    bit st = 1'b0;
    int nf0 = n_fetch;
    mdl_lat = 6;
    @(posedge clk); #1;
    sdr_q.push_back(24'h020040);
    exp_q.push_back(16'h5A40);
    core_addr = 24'h000040;
    core_req = ~core_req;
    for (int i = 0; i < 50 && !st; i++) begin @(negedge clk); if (sdr_req !== sdr_ack) st = 1'b1; end
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); if (core_ack === core_req) ok = 1'b1; end
    tests++; if (!st || !ok || core_data !== 16'h5A40) begin
      fails++; $display("FAIL fmf_deliver: started=%b ok=%b data=%h expected 5A40", st, ok, core_data); end
    mdl_lat = 3;
    do_req(24'h000040, 1'b1, ok);
    tests++; if (!ok || n_fetch !== nf0 + 2) begin
      fails++; $display("FAIL fmf_no_fill: ok=%b fetches=%0d expected 2", ok, n_fetch - nf0); end
    do_req(24'h000040, 1'b0, ok);
    tests++; if (!ok || n_fetch !== nf0 + 2 || hit_cnt !== 16'd1) begin
      fails++; $display("FAIL fmf_refill_hit: ok=%b fetches=%0d hit_cnt=%0d", ok, n_fetch - nf0, hit_cnt); end
  endtask

  task automatic test_reset_mid_fetch;
    bit ok = 1'b0;
    bit st = 1'b0;
    bit quiet = 1'b1;
    int nf0;
    if (sdr_req === 1'b1) do_req(24'h000077, 1'b1, ok);
    nf0 = n_fetch;
    mdl_en = 1'b0;
    @(posedge clk); #1;
    core_addr = 24'h000055;
    core_req = ~core_req;
    for (int i = 0; i < 50 && !st; i++) begin @(negedge clk); if (sdr_req === 1'b1) st = 1'b1; end
    tests++; if (!st) begin fails++; $display("FAIL rmf_start: sdr_req=%b expected 1", sdr_req); end
    VIDEO_RSTn = 1'b0;
    core_req = 1'b0;
    #1;
    tests++; if ({core_ack, sdr_req} !== 2'b00 || core_data !== 16'h0 || sdr_addr !== 24'h0 || hit_cnt !== 16'h0) begin
      fails++; $display("FAIL rmf_reset_outs: ack=%b req=%b data=%h addr=%h hit=%h expected all 0",
                        core_ack, sdr_req, core_data, sdr_addr, hit_cnt); end
    repeat (3) @(negedge clk);
    VIDEO_RSTn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    man_val = 1'b1;
    man_seq++;
    core_addr = 24'h000055;
    core_req = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (sdr_req !== 1'b0 || core_ack !== 1'b0) quiet = 1'b0;
    end
    tests++; if (!quiet) begin fails++; $display("FAIL rmf_resync_hold: sdr_req=%b core_ack=%b expected 0/0", sdr_req, core_ack); end
    @(posedge clk); #1;
    sdr_q.push_back(24'h020055);
    exp_q.push_back(16'h5A55);
    man_val = 1'b0;
    man_seq++;
    mdl_en = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); if (core_ack === 1'b1) ok = 1'b1; end
    tests++; if (!ok || core_data !== 16'h5A55 || n_fetch !== nf0 + 1) begin
      fails++; $display("FAIL rmf_recover: ok=%b data=%h fetches=%0d expected 5A55/1", ok, core_data, n_fetch - nf0); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_cold_miss;
    test_hit;
    test_conflict;
    test_mid_fetch;
    test_flush;
    test_flush_mid_fetch;
    test_reset_mid_fetch;
    repeat (5) @(negedge clk);
    tests++;
    if (exp_q.size() != 0 || sdr_q.size() != 0) begin
      fails++; $display("FAIL sb_drain: %0d words and %0d fetches still expected", exp_q.size(), sdr_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
